frame_update_scheduler: RTL
===========================

FRAME_UPDATE_SCHEDULER -- requirements
Module: frame_update_scheduler

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the per-frame update slot.
REQ-002 Parameter VBLANK_LINE, default 480: first pixelY line outside active video.
REQ-003 Parameter TIMEOUT, default 1023: maximum number of cycles one grant may be held.
REQ-004 clk  input  1: single clock; all state updates occur on its rising edge.
REQ-005 resetN  input  1: synchronous, active-low reset, sampled on rising clk.
REQ-006 pixelX  input  11: current VGA scan column.
REQ-007 pixelY  input  11: current VGA scan line.
REQ-008 req  input  N_REQ: per-requester level request for an update slot in the coming blank.
REQ-009 done  input  N_REQ: per-requester pulse, meaning the granted update has finished.
REQ-010 grant  output  N_REQ: one-hot or zero; the requester currently allowed to update shared game state.
REQ-011 sof  output  1: one-cycle pulse marking the start of vertical blank.
REQ-012 busy  output  1: high whenever the FSM is not in IDLE.
REQ-013 overrun  output  1: one-cycle pulse when the blank window closes with pending requests left unserved.
REQ-014 timeout_err  output  1: one-cycle pulse when a grant is revoked by the timeout.

Function
REQ-015 The blank condition shall be pixelX==0 and pixelY==VBLANK_LINE. sof shall pulse for exactly one cycle, in the cycle after the condition first becomes true (rising-edge detect on a registered compare).
REQ-016 The FSM shall have exactly four states: IDLE, LATCH, ARB and WAIT.
REQ-017 IDLE -> LATCH on sof; busy=0 only in IDLE.
REQ-018 LATCH shall copy req into the pending register, then go to ARB.
REQ-019 In ARB, if pending==0 the FSM shall go to IDLE with no pulse.
REQ-020 In ARB, if pixelY<VBLANK_LINE (active video resumed) and pending!=0, the FSM shall pulse overrun, clear pending and go to IDLE.
REQ-021 Otherwise ARB shall select the lowest index at or after (last+1) mod N_REQ with pending set (round-robin). It shall register grant one-hot to that index, clear the timeout counter and go to WAIT.
REQ-022 Latency: grant shall be asserted one cycle after ARB is entered.
REQ-023 In WAIT, grant shall be held stable and the counter shall increment each cycle, saturating at TIMEOUT.
REQ-024 WAIT shall exit when done[granted] is 1 or the counter equals TIMEOUT.
REQ-025 On WAIT exit, grant shall go to 0 in the same edge, the granted pending bit shall be cleared, last shall be set to the granted index, and the FSM shall go to ARB.
REQ-026 When timeout and done[granted] occur in the same cycle, done shall win and timeout_err shall not pulse.
REQ-027 On a timeout-only exit, timeout_err shall pulse for one cycle.
REQ-028 done bits of non-granted requesters shall be ignored.
REQ-029 req changes after LATCH shall not affect the current frame; a requester dropping req while pending shall still be granted.
REQ-030 A grant in progress when active video resumes shall complete normally; the window is checked only in ARB.
REQ-031 sof arriving while not in IDLE shall be ignored for scheduling (a frame skip), but sof shall still pulse.
REQ-032 At most one grant bit shall be high in any cycle.

Reset
REQ-033 While resetN==0 at a clk edge: state=IDLE; grant, sof, overrun, timeout_err, busy, pending and counter = 0; last = N_REQ-1, so requester 0 is served first.
REQ-034 Reset asserted mid-WAIT shall drop grant on that edge with no timeout_err or overrun pulse.
REQ-035 The first sof after reset release shall be detected only if the blank condition rises after release.

Verification
REQ-036 req=4'b0101, scan to (0,480) -> sof pulses once; grant=0001 until done[0], then 0100 until done[2], then IDLE with busy=0.
REQ-037 Round-robin: last=0, pending=4'b1011 -> grant order 0010, 1000, 0001.
REQ-038 Granted requester never asserts done, TIMEOUT=15 -> grant drops after 15 WAIT cycles, timeout_err pulses once, next pending requester is granted.
REQ-039 req=4'b1111, done withheld until pixelY wraps to 0 -> current grant completes, then overrun pulses, pending clears, FSM enters IDLE.
REQ-040 done[granted] and timeout in the same cycle -> grant released, timeout_err stays 0.
REQ-041 resetN=0 during WAIT with grant=0100 -> next edge grant=0000, busy=0; after release, next frame serves requester 0 first.

Source files
------------

// File: rtl/frame_update_scheduler.sv
// Per-frame update slot scheduler: at the start of vertical blank it latches the
// requesters and grants them one at a time, round-robin, until the blank window closes.
module frame_update_scheduler #(
    parameter int N_REQ       = 4,
    parameter int VBLANK_LINE = 480,
    parameter int TIMEOUT     = 1023
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic [10:0]      pixelX,
    input  logic [10:0]      pixelY,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] grant,
    output logic             sof,
    output logic             busy,
    output logic             overrun,
    output logic             timeout_err
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, LATCH, ARB, WAIT} state_t;

    state_t           state, state_nxt;
    logic             blank_now, blank_q, blank_prev;
    logic [N_REQ-1:0] pending, pending_nxt, grant_nxt;
    logic [IW-1:0]    last, last_nxt, gidx, gidx_nxt, pick;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             overrun_nxt, terr_nxt;

    assign blank_now = (pixelX == 11'd0) && (pixelY == 11'(VBLANK_LINE));
    assign sof       = blank_q & ~blank_prev;
    assign busy      = (state != IDLE);

    // blank_q keeps tracking through reset so a condition already true at release is not a rise
    always_ff @(posedge clk) begin
        blank_q <= blank_now;
        if (!resetN) blank_prev <= 1'b1;
        else         blank_prev <= blank_q;
    end

    // Descending scan so the smallest offset from last+1 wins.
    always_comb begin
        pick = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            if (pending[(int'(last) + i) % N_REQ]) pick = IW'((int'(last) + i) % N_REQ);
        end
    end

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        grant_nxt   = grant;
        last_nxt    = last;
        gidx_nxt    = gidx;
        cnt_nxt     = cnt;
        overrun_nxt = 1'b0;
        terr_nxt    = 1'b0;
        unique case (state)
            IDLE: if (sof) state_nxt = LATCH;
            LATCH: begin
                pending_nxt = req;
                state_nxt   = ARB;
            end
            ARB: begin
                if (pending == '0) begin
                    state_nxt = IDLE;
                end else if (pixelY < 11'(VBLANK_LINE)) begin
                    overrun_nxt = 1'b1;
                    pending_nxt = '0;
                    state_nxt   = IDLE;
                end else begin
                    gidx_nxt        = pick;
                    grant_nxt       = '0;
                    grant_nxt[pick] = 1'b1;
                    cnt_nxt         = '0;
                    state_nxt       = WAIT;
                end
            end
            WAIT: begin
                // done takes priority over an expiring counter
                if (done[gidx] || cnt == CW'(TIMEOUT)) begin
                    terr_nxt          = ~done[gidx];
                    grant_nxt         = '0;
                    pending_nxt[gidx] = 1'b0;
                    last_nxt          = gidx;
                    state_nxt         = ARB;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state       <= IDLE;
            pending     <= '0;
            grant       <= '0;
            last        <= IW'(N_REQ - 1);
            gidx        <= '0;
            cnt         <= '0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            pending     <= pending_nxt;
            grant       <= grant_nxt;
            last        <= last_nxt;
            gidx        <= gidx_nxt;
            cnt         <= cnt_nxt;
            overrun     <= overrun_nxt;
            timeout_err <= terr_nxt;
        end
    end

endmodule
